spi_xfer_ctrl: RTL
==================

Name: spi_xfer_ctrl

Overview:
- SPI master transfer sequencer for the SPI IP.
- Accepts a one-cycle start pulse from the bus-side write edge detector and latches the TX word.
- Drives cs_n, sclk and mosi through one full-duplex word transfer, then returns the received word with a one-cycle done pulse.
- Sits between the register interface and the SPI pins.

Parameters:
- DATA_W, 8: transfer word width in bits (≥2).
- CLK_DIV, 4: sclk half-period in clk cycles (≥1).
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_pulse  in  1  single-cycle transfer request.
- tx_data  in  DATA_W  word to send; sampled only when start is accepted.
- miso  in  1  serial data from slave.
- busy  out  1  high from start acceptance until done_pulse.
- done_pulse  out  1  one-cycle completion strobe.
- rx_data  out  DATA_W  last received word; held until the next completion.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data to slave, MSB first.
- cs_n  out  1  active-low chip select.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; sclk=CPOL, cs_n=1, mosi=0, busy=0, done_pulse=0, rx_data=0.
  - Shift register, divider counter and edge counter cleared.
- Reset mid-transfer aborts at once. No done_pulse is produced and rx_data is cleared.
- IDLE:
  - start_pulse=1 → tx_data loads into the shift register; cs_n←0, busy←1, go to SETUP.
  - CPHA=0: mosi←tx_data[DATA_W-1] at the same edge.
- SETUP: CLK_DIV cycles with sclk at CPOL, then go to XFER.
- XFER:
  - Divider counts 0..CLK_DIV-1; at terminal count sclk toggles and the counter wraps.
  - Exactly 2*DATA_W toggles; odd toggles are leading edges, even toggles are trailing edges.
  - CPHA=0: leading edge samples miso into the shift-register LSB; trailing edge shifts left and drives the next MSB onto mosi. The final trailing edge does not change mosi.
  - CPHA=1: leading edge shifts and drives the MSB onto mosi; trailing edge samples miso.
  - After the 2*DATA_W-th toggle (sclk back at CPOL), go to HOLD.
- HOLD: CLK_DIV cycles. At the end: cs_n←1, busy←0, rx_data←shift register, done_pulse←1 for one cycle, state←IDLE.
- Latency: the start_pulse edge to the first edge with done_pulse=1 is exactly (2*DATA_W+2)*CLK_DIV+1 clk cycles.
- start_pulse while busy=1 is ignored, with no queueing and no error.
- start_pulse in the same cycle done_pulse is high is accepted, because state is already IDLE. This gives back-to-back transfers with cs_n high for exactly one cycle.
- tx_data changes after acceptance do not affect the transfer in flight.
- All outputs are registered; sclk, mosi and cs_n are glitch-free.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the sampled data is mosi internally and the miso pin is ignored. sclk, cs_n and mosi still toggle at the pins. loopback is sampled at start acceptance and held for the whole transfer.
- Not defined: no loopback port; miso is always sampled.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, tx_data=0xA5, slave model returns 0x3C:
  - mosi sampled on rising sclk = 1,0,1,0,0,1,0,1.
  - rx_data=0x3C; done_pulse 37 cycles after start; 16 sclk toggles; sclk idles 0.
- Mode 3 (CPOL=1, CPHA=1), same stimulus:
  - sclk idles 1; mosi changes on falling edges; slave samples 0xA5 on rising edges.
  - rx_data=0x3C; latency 37.
- Second start_pulse 10 cycles after the first, tx_data=0xFF:
  - Ignored; the transfer completes with mosi pattern 0xA5.
  - Exactly one done_pulse; busy stays continuously high.
- Reset asserted at cycle 15 of a transfer:
  - All outputs reach reset values asynchronously (cs_n=1, sclk=CPOL, busy=0, rx_data=0).
  - No done_pulse; a new start afterwards completes normally.
- start_pulse in the done_pulse cycle with tx_data=0x5A:
  - cs_n high exactly 1 cycle; second transfer sends 0x5A; second done_pulse 37 cycles later.
- SPI_LOOPBACK_EN defined, loopback=1, tx_data=0xC3, miso tied 0 → rx_data=0xC3.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: one full-duplex DATA_W-bit word per start
// pulse, MSB first. The phases are IDLE, SETUP, XFER and HOLD.
// Optional feature macro: SPI_LOOPBACK_EN. When it is defined, the block has a
// loopback input. When loopback is sampled high at start, mosi is fed back in
// place of miso.
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_pulse,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              busy,
  output logic              done_pulse,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic [DATA_W-1:0]   sr_q;
  logic                rxb_q;
  logic                sclk_q;
  logic                mosi_q;
  logic                cs_n_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   rx_q;
  logic                lb_q;

  logic                rx_in;
  logic                div_tc;
  logic                leading;
  logic                last_edge;

  // Receive source, divider terminal count and sclk edge classification
  always_comb begin
    rx_in     = lb_q ? mosi_q : miso;
    div_tc    = (div_q == DIV_LAST);
    leading   = ~edge_q[0];
    last_edge = (edge_q == EDGE_LAST);
  end

  // Transfer sequencer with all pin and status outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      sr_q    <= '0;
      rxb_q   <= 1'b0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      lb_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            sr_q    <= tx_data;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            edge_q  <= '0;
            if (!CPHA) mosi_q <= tx_data[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
            lb_q    <= loopback;
`else
            lb_q    <= 1'b0;
`endif
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (div_tc) begin
            div_q   <= '0;
            state_q <= XFER;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        XFER: begin
          if (div_tc) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            // With CPHA=0 the sampled bit is parked in rxb_q until the
            // trailing shift. This keeps tx bits still to be sent intact.
            if (leading) begin
              if (!CPHA) begin
                rxb_q <= rx_in;
              end else begin
                mosi_q <= sr_q[DATA_W-1];
                sr_q   <= {sr_q[DATA_W-2:0], 1'b0};
              end
            end else begin
              if (!CPHA) begin
                sr_q <= {sr_q[DATA_W-2:0], rxb_q};
                if (!last_edge) mosi_q <= sr_q[DATA_W-2];
              end else begin
                sr_q <= {sr_q[DATA_W-1:1], rx_in};
              end
            end
            if (last_edge) state_q <= HOLD;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        HOLD: begin
          if (div_tc) begin
            div_q   <= '0;
            edge_q  <= '0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            rx_q    <= sr_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign rx_data    = rx_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;

endmodule
